// File: rtl/decode.sv
// RISC-V ID stage: register file, immediate generation, control decode
// and the ID/EX pipeline register feeding the execute stage.
module decode #(
    parameter logic [31:0] REG_RESET = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instrD,
    input  logic [31:0] PCD,
    input  logic        flushE,
    input  logic        regWriteW,
    input  logic [4:0]  rdW,
    input  logic [31:0] resultW,
    output logic [31:0] RD1E,
    output logic [31:0] RD2E,
    output logic [31:0] immExtE,
    output logic [31:0] PCE,
    output logic [4:0]  rs1E,
    output logic [4:0]  rs2E,
    output logic [4:0]  rdE,
    output logic        regWriteE,
    output logic        memWriteE,
    output logic        branchE,
    output logic        jumpE,
    output logic        ALUsrcE,
    output logic [1:0]  resultSrcE,
    output logic [2:0]  ALUcontrolE
);
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    logic [31:0] r_rf [32];

    logic [6:0]  w_op;
    logic [2:0]  w_f3;
    logic        w_f7b5;
    logic [4:0]  w_rs1;
    logic [4:0]  w_rs2;
    logic [4:0]  w_rd;
    logic [31:0] w_rd1;
    logic [31:0] w_rd2;
    logic [31:0] w_imm;
    logic        w_rw;
    logic        w_mw;
    logic        w_br;
    logic        w_jp;
    logic        w_as;
    logic [1:0]  w_rs;
    logic [2:0]  w_alu;

    assign w_op   = instrD[6:0];
    assign w_f3   = instrD[14:12];
    assign w_f7b5 = instrD[30];
    assign w_rs1  = instrD[19:15];
    assign w_rs2  = instrD[24:20];
    assign w_rd   = instrD[11:7];

    function automatic logic [2:0] alu_dec(input logic [2:0] f3,
                                           input logic sub);
        case (f3)
            3'b000:  return sub ? 3'b001 : 3'b000;
            3'b010:  return 3'b101;
            3'b110:  return 3'b011;
            3'b111:  return 3'b010;
            default: return 3'b000;
        endcase
    endfunction

    // Write-first bypass: a same-cycle write-back is seen by the read.
    always_comb begin
        w_rd1 = r_rf[w_rs1];
        w_rd2 = r_rf[w_rs2];
        if (regWriteW && rdW == w_rs1) w_rd1 = resultW;
        if (regWriteW && rdW == w_rs2) w_rd2 = resultW;
        if (w_rs1 == 5'd0) w_rd1 = '0;
        if (w_rs2 == 5'd0) w_rd2 = '0;
    end

    always_comb begin
        w_rw  = 1'b0;
        w_mw  = 1'b0;
        w_br  = 1'b0;
        w_jp  = 1'b0;
        w_as  = 1'b0;
        w_rs  = 2'b00;
        w_alu = 3'b000;
        w_imm = '0;
        case (w_op)
            OP_LW: begin
                w_rw  = 1'b1;
                w_as  = 1'b1;
                w_rs  = 2'b01;
                w_imm = {{20{instrD[31]}}, instrD[31:20]};
            end
            OP_SW: begin
                w_mw  = 1'b1;
                w_as  = 1'b1;
                w_imm = {{20{instrD[31]}}, instrD[31:25], instrD[11:7]};
            end
            OP_R: begin
                w_rw  = 1'b1;
                w_alu = alu_dec(w_f3, w_f7b5);
            end
            OP_I: begin
                w_rw  = 1'b1;
                w_as  = 1'b1;
                w_alu = alu_dec(w_f3, 1'b0);
                w_imm = {{20{instrD[31]}}, instrD[31:20]};
            end
            OP_BEQ: begin
                w_br  = 1'b1;
                w_alu = 3'b001;
                w_imm = {{20{instrD[31]}}, instrD[7], instrD[30:25],
                         instrD[11:8], 1'b0};
            end
            OP_JAL: begin
                w_rw  = 1'b1;
                w_jp  = 1'b1;
                w_rs  = 2'b10;
                w_imm = {{12{instrD[31]}}, instrD[19:12], instrD[20],
                         instrD[30:21], 1'b0};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rf[0] <= '0;
            for (int i = 1; i < 32; i++) r_rf[i] <= REG_RESET;
        end else if (regWriteW && rdW != 5'd0) begin
            r_rf[rdW] <= resultW;
        end
    end

    // ID/EX register; a flush turns the slot into an all-zero bubble.
    always_ff @(posedge clk) begin
        if (rst || flushE) begin
            RD1E        <= '0;
            RD2E        <= '0;
            immExtE     <= '0;
            PCE         <= '0;
            rs1E        <= '0;
            rs2E        <= '0;
            rdE         <= '0;
            regWriteE   <= 1'b0;
            memWriteE   <= 1'b0;
            branchE     <= 1'b0;
            jumpE       <= 1'b0;
            ALUsrcE     <= 1'b0;
            resultSrcE  <= '0;
            ALUcontrolE <= '0;
        end else begin
            RD1E        <= w_rd1;
            RD2E        <= w_rd2;
            immExtE     <= w_imm;
            PCE         <= PCD;
            rs1E        <= w_rs1;
            rs2E        <= w_rs2;
            rdE         <= w_rd;
            regWriteE   <= w_rw;
            memWriteE   <= w_mw;
            branchE     <= w_br;
            jumpE       <= w_jp;
            ALUsrcE     <= w_as;
            resultSrcE  <= w_rs;
            ALUcontrolE <= w_alu;
        end
    end
endmodule

// File: doc/decode.md
DECODE -- requirements
Module: decode

Interface
REQ-001 SHALL have parameter REG_RESET, default 32'h0000_0000, the value loaded into x1..x31 on reset.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port instrD  input  32  instruction from the fetch pipeline register.
REQ-005 SHALL have port PCD  input  32  PC of instrD.
REQ-006 SHALL have port flushE  input  1  when high, the next EX contents become a bubble.
REQ-007 SHALL have write-back ports: regWriteW input 1 (write enable), rdW input 5 (destination), resultW input 32 (write data).
REQ-008 SHALL have data outputs: RD1E 32, RD2E 32, immExtE 32, PCE 32, rs1E 5, rs2E 5, rdE 5.
REQ-009 SHALL have control outputs: regWriteE 1, memWriteE 1, branchE 1, jumpE 1, ALUsrcE 1, resultSrcE 2, ALUcontrolE 3.

Function
REQ-010 SHALL contain a 32x32 register file; x0 SHALL always read 0.
REQ-011 SHALL write resultW to x[rdW] on the clock edge when regWriteW=1 and rdW!=0; a write to x0 SHALL be discarded.
REQ-012 SHALL read rs1=instrD[19:15] and rs2=instrD[24:20] combinationally; if regWriteW=1, rdW!=0 and rdW equals the read index, SHALL return resultW (write-first bypass).
REQ-013 SHALL generate sign-extended immediates: I (opcode 0000011, 0010011), S (0100011), B (1100011, bit0=0), J (1101111, bit0=0).
REQ-014 SHALL decode opcodes into the following controls:
- lw: regWrite=1, ALUsrc=1, resultSrc=01, ALUctl=000.
- sw: memWrite=1, ALUsrc=1, ALUctl=000.
- R-type (0110011): regWrite=1, ALUctl from funct3/funct7.
- I-ALU (0010011): regWrite=1, ALUsrc=1, ALUctl from funct3.
- beq: branch=1, ALUctl=001.
- jal: regWrite=1, jump=1, resultSrc=10.
REQ-015 SHALL encode ALUcontrol as 000 add, 001 sub (R-type funct7[5]=1 with funct3=000), 010 and, 011 or, 101 slt; an unlisted funct3 SHALL give 000.
REQ-016 SHALL force all controls to 0 (NOP) for any unlisted opcode, including instrD=0.
REQ-017 SHALL register all E outputs in an ID/EX pipeline register, giving 1-cycle latency from instrD/PCD to the E outputs.
REQ-018 SHALL, when flushE=1 at a clock edge, load 0 into all control outputs and all data outputs on that edge.
REQ-019 SHALL let the register-file write (REQ-011) still occur when flushE=1 and regWriteW=1 in the same cycle.

Reset
REQ-020 SHALL, on a clock edge with rst=1, clear every E output to 0 and load REG_RESET into x1..x31; write-back is ignored on that edge.
REQ-021 SHALL give rst priority over flushE and over write-back.
REQ-022 SHALL resume normal decode on the first edge after rst falls.

Verification
REQ-023 SHALL be checked with: instrD=0x00500093 (addi x1,x0,5) -> next cycle immExtE=5, regWriteE=1, ALUsrcE=1, rdE=1, ALUcontrolE=000.
REQ-024 SHALL be checked with: regWriteW=1, rdW=1, resultW=0x12345678 in the same cycle as instrD=0x002081B3 (add x3,x1,x2) -> next cycle RD1E=0x12345678 (bypass), rdE=3.
REQ-025 SHALL be checked with: write rdW=0 with resultW=0xFFFFFFFF, then decode an instruction with rs1=x0 -> RD1E=0.
REQ-026 SHALL be checked with: instrD=0xFE208EE3 (beq x1,x2,-4) -> immExtE=0xFFFFFFFC, branchE=1, ALUcontrolE=001, regWriteE=0; instrD=0x0020A423 (sw) -> immExtE=8, memWriteE=1.
REQ-027 SHALL be checked with: flushE=1 while a valid lw is decoded -> next cycle all E outputs 0; a same-cycle write-back is still visible on a later read.
REQ-028 SHALL be checked with: rst=1 mid-stream after x5 was written -> next cycle all E outputs 0, and a subsequent read of x5 returns REG_RESET.
